// File: rtl/main.sv
// Instruction-fetch stage: a 32-bit PC register feeding a combinational
// read-only instruction memory. The PC is loaded from PCin_top on every
// rising clock edge. All next-PC arithmetic is done outside this block.
//
// Optional build macro: MAIN_PC_ALIGN_EN
//   When defined, the PC register clears its two low bits on load.
//   When undefined, the PC register stores PCin_top exactly as given.
//   In both builds the two low bits never take part in memory indexing.
module main #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] PC_RESET   = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCin_top,
  output logic [31:0] instruction_top
);

  // Number of word-index bits: PC[ADDR_W+1:2] selects a memory word.
  localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);

  // Word returned for unused and out-of-range locations (addi x0,x0,0).
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  logic [31:0]       pc_d;
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] word_idx_s;
  logic              out_of_range_s;
  logic [31:0]       rom_word_s;
  logic              unused_pc_low_bits_s;

  // Built-in program image. Any index not listed here reads as a NOP.
  function automatic logic [31:0] rom_lookup(input logic [ADDR_W-1:0] idx);
    logic [31:0] word;
    case (32'(idx))
      32'd0:   word = 32'h00500093;  // addi x1, x0, 5
      32'd1:   word = 32'h00A00113;  // addi x2, x0, 10
      32'd2:   word = 32'h002081B3;  // add  x3, x1, x2
      32'd3:   word = 32'h40208233;  // sub  x4, x1, x2
      32'd4:   word = 32'h0020F2B3;  // and  x5, x1, x2
      32'd5:   word = 32'h0020E333;  // or   x6, x1, x2
      default: word = NOP_WORD;
    endcase
    return word;
  endfunction

  // Next PC value. This is a straight copy of the input, optionally word-aligned.
  always_comb begin
    pc_d = PCin_top;
`ifdef MAIN_PC_ALIGN_EN
    pc_d = {PCin_top[31:2], 2'b00};
`else
    pc_d = PCin_top;
`endif
  end

  // PC register. It reloads every cycle, and reset forces PC_RESET at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Split the PC into a word index and the out-of-range upper bits.
  always_comb begin
    word_idx_s     = pc_q[ADDR_W+1:2];
    out_of_range_s = (pc_q[31:ADDR_W+2] != '0);
  end

  // Combinational fetch. A non-zero upper field always yields a NOP.
  always_comb begin
    rom_word_s = rom_lookup(word_idx_s);
    if (out_of_range_s) begin
      instruction_top = NOP_WORD;
    end else begin
      instruction_top = rom_word_s;
    end
  end

  // The byte-offset bits are held in the PC but play no part in the fetch.
  always_comb begin
    unused_pc_low_bits_s = ^pc_q[1:0];
  end

endmodule

// File: tb/tb_main.sv
// Directed, table-driven bench for the instruction-fetch block "main".
// Expected instruction words and stored-PC values are written out by hand
// from the memory image and the address-decoding rules.
module tb_main;

  logic        clk;
  logic        reset;
  logic [31:0] PCin_top;
  logic [31:0] instruction_top;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] pc_in;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[14];

  main #(
    .IMEM_DEPTH(64),
    .PC_RESET  (32'h00000000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PCin_top       (PCin_top),
    .instruction_top(instruction_top)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected stored PC for a given input, depending on the build option.
  function automatic logic [31:0] exp_pc(input logic [31:0] pc_in);
    logic [31:0] r;
`ifdef MAIN_PC_ALIGN_EN
    r = {pc_in[31:2], 2'b00};
`else
    r = pc_in;
`endif
    return r;
  endfunction

  // Drive a new PC, wait for the edge that loads it, then sample 1 ns later.
  task automatic step(input logic [31:0] pc_in);
    PCin_top = pc_in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    PCin_top = 32'h00000040;

    vecs[0]  = '{32'h00000004, 32'h00A00113};
    vecs[1]  = '{32'h00000008, 32'h002081B3};
    vecs[2]  = '{32'h0000000C, 32'h40208233};
    vecs[3]  = '{32'h0000000C, 32'h40208233};  // same value is reloaded
    vecs[4]  = '{32'h00000010, 32'h0020F2B3};
    vecs[5]  = '{32'h00000014, 32'h0020E333};
    vecs[6]  = '{32'h00000018, 32'h00000013};
    vecs[7]  = '{32'h00000000, 32'h00500093};
    vecs[8]  = '{32'h00000100, 32'h00000013};  // just beyond the 64 words
    vecs[9]  = '{32'hFFFFFFFC, 32'h00000013};
    vecs[10] = '{32'h000000FC, 32'h00000013};  // last word, a NOP
    vecs[11] = '{32'h00000005, 32'h00A00113};  // byte offset ignored
    vecs[12] = '{32'h0000000B, 32'h002081B3};
    vecs[13] = '{32'h00000102, 32'h00000013};

    // Reset is held from time 0. Check before any clock edge.
    #1;
    check("reset_pc_before_edge", dut.pc_q, 32'h00000000);
    check("reset_instr_before_edge", instruction_top, 32'h00500093);

    // Reset dominates the clock, so PCin_top=0x40 is not loaded.
    @(posedge clk);
    #1;
    check("reset_pc_held_over_edge", dut.pc_q, 32'h00000000);
    check("reset_instr_held_over_edge", instruction_top, 32'h00500093);

    // Release reset between edges. The PC must not move until the next edge.
    reset = 1'b0;
    #1;
    check("release_no_edge_pc", dut.pc_q, 32'h00000000);

    // Apply the vector table.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].pc_in);
      check($sformatf("vec%0d_instr", i), instruction_top, vecs[i].exp_instr);
      check($sformatf("vec%0d_pc", i), dut.pc_q, exp_pc(vecs[i].pc_in));
    end

    // Assert reset asynchronously between edges while PC is 12.
    step(32'h0000000C);
    check("pre_async_instr", instruction_top, 32'h40208233);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_instr", instruction_top, 32'h00500093);
    check("async_reset_pc", dut.pc_q, 32'h00000000);

    // The in-flight PC value is discarded while reset is held.
    PCin_top = 32'h00000014;
    @(posedge clk);
    #1;
    check("reset_discards_pc", dut.pc_q, 32'h00000000);
    reset = 1'b0;

    // The first edge after release loads PCin_top.
    step(32'h00000014);
    check("post_reset_20_instr", instruction_top, 32'h0020E333);
    step(32'h00000018);
    check("post_reset_24_instr", instruction_top, 32'h00000013);
    check("post_reset_24_pc", dut.pc_q, 32'h00000018);

    // Unaligned PC of 5 fetches word1 and is stored according to the build option.
    step(32'h00000005);
    check("pc5_instr", instruction_top, 32'h00A00113);
`ifdef MAIN_PC_ALIGN_EN
    check("pc5_stored", dut.pc_q, 32'h00000004);
`else
    check("pc5_stored", dut.pc_q, 32'h00000005);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter IMEM_DEPTH, default 64: instruction memory depth in 32-bit words (power of two, 16..1024).
REQ-002 Parameter PC_RESET, default 32'h00000000: PC value loaded by reset.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port PCin_top  input  32: next program-counter value, sampled each rising clk edge.
REQ-006 Port instruction_top  output  32: instruction word fetched at the current PC.
REQ-007 The block SHALL use one clock, clk, with reset asynchronous and active-high.

Function
REQ-008 The block SHALL hold a 32-bit PC register that loads PCin_top on every rising clk edge while reset is low.
REQ-009 The block SHALL have no enable and no hold: the PC register reloads every cycle, even when PCin_top equals the current PC.
REQ-010 Instruction memory SHALL be a read-only word array of IMEM_DEPTH entries, indexed by PC[log2(IMEM_DEPTH)+1:2].
REQ-011 Instruction memory SHALL be read combinationally.
- instruction_top reflects the new PC in the same cycle as the PC update.
- Latency: PCin_top to instruction_top is one clock edge.
REQ-012 Built-in memory contents SHALL be as follows; all other words are 32'h00000013 (NOP).
- word0 = 32'h00500093
- word1 = 32'h00A00113
- word2 = 32'h002081B3
- word3 = 32'h40208233
- word4 = 32'h0020F2B3
- word5 = 32'h0020E333
REQ-013 Out-of-range fetch: if PC[31:log2(IMEM_DEPTH)+2] is non-zero, instruction_top SHALL be 32'h00000013.
REQ-014 With alignment forcing not compiled in, PC[1:0] SHALL be stored as given and ignored for indexing, so PC 5 fetches word1.
REQ-015 PC arithmetic SHALL be external: the block performs no increment or wrap, and stores the full 32 bits unchanged except as REQ-019 specifies.
REQ-016 instruction_top SHALL be a pure function of the PC register and SHALL never be X after reset.

Reset
REQ-017 While reset is high, the PC register SHALL equal PC_RESET immediately, without waiting for a clock edge, and instruction_top SHALL show the word at PC_RESET (32'h00500093 by default).
REQ-018 Reset SHALL dominate clk.
- A reset asserted mid-operation discards the in-flight PCin_top.
- After reset deasserts, the first rising edge loads PCin_top.

Configuration
REQ-019 When macro MAIN_PC_ALIGN_EN is defined, the PC register SHALL store {PCin_top[31:2],2'b00}; when it is undefined, the PC register SHALL store PCin_top unmodified.

Verification
REQ-020 Scenario: reset=1, clk toggling -> PC=0 and instruction_top=32'h00500093 before any clock edge.
REQ-021 Scenario: release reset, then apply PCin_top 4, 8, 12 on successive edges -> instruction_top = 32'h00A00113, 32'h002081B3, 32'h40208233 one edge after each value is applied.
REQ-022 Scenario: reset asserted between edges while PC=12 -> instruction_top returns to 32'h00500093 asynchronously; after release, PCin_top 20 then 24 -> 32'h0020E333, then 32'h00000013.
REQ-023 Scenario: PCin_top = 32'h00000100 (IMEM_DEPTH=64) -> instruction_top=32'h00000013; PCin_top = 32'hFFFFFFFC -> 32'h00000013.
REQ-024 Scenario: PCin_top=5 -> instruction_top=32'h00A00113; the stored PC reads 5 without MAIN_PC_ALIGN_EN and 4 with MAIN_PC_ALIGN_EN.
